serial_addsub: RTL

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_pkg.sv | 7 +
 rtl/full_adder.sv | 11 +
 rtl/serial_addsub.sv | 70 +++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared FSM encoding and counter sizing for the bit-serial adder/subtractor.
package serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder reused every RUN cycle.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract, one bit per cycle LSB first, valid/ready handshake on both sides.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);
  localparam int CW = cnt_w(N);
  state_t state, state_n;
  logic [N-1:0] a_sr, b_sr, s_sr, s_nx;
  logic [CW-1:0] cnt;
  logic c, sum, co, last;
  full_adder fa (.x(a_sr[0]), .y(b_sr[0]), .ci(c), .sum(sum), .co(co));
  // result bits enter at the MSB so the word is aligned after N shifts
  if (N == 1) begin : g_one
    assign s_nx = sum;
  end else begin : g_many
    assign s_nx = {sum, s_sr[N-1:1]};
  end
  assign last = cnt == CW'(N - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign s = s_sr;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && in_valid) state_n = RUN;
    if (state == RUN && last) state_n = DONE;
    if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      s_sr <= '0;
      cnt <= '0;
      c <= 1'b0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sr <= a;
      b_sr <= sub ? ~b : b;
      c <= sub ? ~cin : cin;
      cnt <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      s_sr <= s_nx;
      c <= co;
      if (last) begin
        cout <= co;
        ovf <= c ^ co;
      end else cnt <= cnt + CW'(1);
    end
endmodule
